// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: pipelined in-order word fetch feeding a
// small FIFO of {instruction, pc} entries, with redirect flush/discard.
module instr_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard;
    logic [CW-1:0] inflight_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   push_pc;
    logic [31:0]   target_pc;
    logic [CW:0]   occupancy;
    logic          accept;
    logic          resp;
    logic          push;
    logic          pop;

    // Credit rule: queued entries plus outstanding reads never exceed DEPTH
    assign occupancy   = {1'b0, count} + {1'b0, inflight};
    assign mem_req     = !reset && !redirect && (occupancy < DEPTH_W);
    assign mem_addr    = fetch_pc;
    assign accept      = mem_req && mem_ready;

    // Responses with nothing outstanding are stray and ignored
    assign resp        = mem_rvalid && (inflight != '0);
    assign push        = !reset && !redirect && resp && (discard == '0);
    assign pop         = instr_valid && instr_ready && !redirect;

    assign instr_valid = (count != '0);
    assign instr_out   = instr_valid ? data_q[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? pc_q[rd_ptr] : '0;
    assign target_pc   = redirect_pc & 32'hFFFF_FFFC;

    // Outstanding-request count after this cycle's issue and return
    always_comb begin
        inflight_next = inflight + CW'(accept) - CW'(resp);
    end

    // Write the returned word and its PC at the tail
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= mem_rdata;
            pc_q[wr_ptr]   <= push_pc;
        end
    end

    // Pointers, counters and fetch/push PCs; redirect flushes and
    // marks everything still in flight for discard
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            push_pc  <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
        end else if (redirect) begin
            fetch_pc <= target_pc;
            push_pc  <= target_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= inflight_next;
            discard  <= inflight_next;
        end else begin
            inflight <= inflight_next;
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (resp && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
            if (push) begin
                wr_ptr  <= wr_ptr + PW'(1);
                push_pc <= push_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: directed tables and sequences plus
// randomized traffic against a queue-based reference model.
module tb_instr_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    instr_prefetch_queue #(
        .DEPTH(DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .instr_valid(instr_valid),
        .instr_out(instr_out),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_out;
    } vec_t;

    ent_t        mq[$];
    pend_t       pq[$];
    int          m_inflight;
    int          m_discard;
    logic [31:0] m_fetch;
    logic [31:0] m_push;

    int n_cmp;
    int n_bad;
    int cyc;
    int last_due;
    int lat_min;
    int lat_max;
    bit chk_en;

    logic        t_rst;
    logic        t_redir;
    logic [31:0] t_rpc;
    logic        t_rdy;
    logic        t_mrdy;
    logic        t_spur;

    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_out;
    logic [31:0] s_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0060_0513;
            32'h4:   return 32'h0010_0293;
            32'h8:   return 32'h0010_0593;
            32'hC:   return 32'h02b2_82b3;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event never seen within bound", name);
    endtask

    // One clock: drive inputs, sample and compare, then advance the
    // memory model and the reference queue model.
    task automatic cycle();
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_out;
        logic [31:0] e_pc;
        logic        rv;
        logic [31:0] rd;
        logic        acc;
        logic        rsp;
        int          d;
        @(negedge clk);
        reset       = t_rst;
        redirect    = t_redir;
        redirect_pc = t_rpc;
        instr_ready = t_rdy;
        mem_ready   = t_mrdy;
        rv = 1'b0;
        rd = '0;
        if (!t_rst && pq.size() > 0 && pq[0].due <= cyc) begin
            rv = 1'b1;
            rd = mem_word(pq[0].addr);
        end else if (!t_rst && t_spur && pq.size() == 0) begin
            rv = 1'b1;
            rd = 32'hDEAD_BEEF;
        end
        mem_rvalid = rv;
        mem_rdata  = rd;
        #1;
        s_req   = mem_req;
        s_addr  = mem_addr;
        s_valid = instr_valid;
        s_out   = instr_out;
        s_pc    = instr_pc;
        e_req   = !t_rst && !t_redir && (mq.size() + m_inflight < DEPTH);
        e_valid = (mq.size() != 0);
        e_out   = e_valid ? mq[0].data : 32'h0;
        e_pc    = e_valid ? mq[0].pc : 32'h0;
        if (chk_en) begin
            check("mem_req", {31'b0, s_req}, {31'b0, e_req});
            check("mem_addr", s_addr, m_fetch);
            check("instr_valid", {31'b0, s_valid}, {31'b0, e_valid});
            check("instr_out", s_out, e_out);
            check("instr_pc", s_pc, e_pc);
        end
        if (rv && pq.size() > 0 && pq[0].due <= cyc) begin
            void'(pq.pop_front());
        end
        if (t_rst) begin
            pq.delete();
            last_due = 0;
        end else if (mem_req && t_mrdy) begin
            d = cyc + $urandom_range(lat_min, lat_max);
            if (d <= last_due) d = last_due + 1;
            pq.push_back('{due: d, addr: mem_addr});
            last_due = d;
        end
        if (t_rst) begin
            mq.delete();
            m_inflight = 0;
            m_discard  = 0;
            m_fetch    = RESET_PC;
            m_push     = RESET_PC;
        end else begin
            acc = e_req && t_mrdy;
            rsp = rv && (m_inflight > 0);
            if (t_redir) begin
                mq.delete();
                m_inflight = m_inflight - int'(rsp);
                m_discard  = m_inflight;
                m_fetch    = t_rpc & 32'hFFFF_FFFC;
                m_push     = t_rpc & 32'hFFFF_FFFC;
            end else begin
                if (e_valid && t_rdy) void'(mq.pop_front());
                if (rsp) begin
                    m_inflight--;
                    if (m_discard > 0) begin
                        m_discard--;
                    end else begin
                        mq.push_back('{pc: m_push, data: rd});
                        m_push = m_push + 32'd4;
                    end
                end
                if (acc) begin
                    m_fetch = m_fetch + 32'd4;
                    m_inflight++;
                end
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        t_rst   = 1'b1;
        t_redir = 1'b0;
        cycle();
        t_rst = 1'b0;
    endtask

    vec_t        vt[8];
    logic [31:0] wrap_pc[4];
    logic [31:0] exp_seq;
    int          k;
    int          seen;
    bit          found;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        last_due = 0;
        chk_en = 1'b0;
        lat_min = 1;
        lat_max = 1;
        m_inflight = 0;
        m_discard = 0;
        m_fetch = RESET_PC;
        m_push = RESET_PC;
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        t_rst = 1'b1;
        t_redir = 1'b0;
        t_rpc = '0;
        t_rdy = 1'b1;
        t_mrdy = 1'b1;
        t_spur = 1'b0;

        // Reset then stream from 1-cycle memory
        vt[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
        vt[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
        vt[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0};
        vt[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0};
        vt[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0060_0513};
        vt[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h4, 32'h0010_0293};
        vt[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h8, 32'h0010_0593};
        vt[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hC, 32'h02b2_82b3};
        for (int i = 0; i < 8; i++) begin
            t_rst = vt[i].rst;
            t_rdy = vt[i].rdy;
            cycle();
            chk_en = 1'b1;
            if (i > 0) begin
                check("t1_req", {31'b0, s_req}, {31'b0, vt[i].e_req});
                check("t1_valid", {31'b0, s_valid}, {31'b0, vt[i].e_valid});
                check("t1_pc", s_pc, vt[i].e_pc);
                check("t1_out", s_out, vt[i].e_out);
            end
        end

        // Core stalls: queue fills, fetching stops, head holds
        do_reset();
        t_rdy = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        check("t2_req_stop", {31'b0, s_req}, 32'h0);
        check("t2_valid", {31'b0, s_valid}, 32'h1);
        check("t2_hold_out", s_out, 32'h0060_0513);
        check("t2_hold_pc", s_pc, 32'h0);
        t_rdy = 1'b1;
        exp_seq = 32'h0;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (s_valid) begin
                check("t2_seq_pc", s_pc, exp_seq);
                check("t2_seq_out", s_out, mem_word(exp_seq));
                exp_seq = exp_seq + 32'd4;
            end
        end

        // Redirect with two reads outstanding at latency 3
        lat_min = 3;
        lat_max = 3;
        do_reset();
        t_rdy = 1'b1;
        cycle();
        cycle();
        t_redir = 1'b1;
        t_rpc = 32'h0000_0103;
        cycle();
        check("t3_req_redir", {31'b0, s_req}, 32'h0);
        t_redir = 1'b0;
        found = 1'b0;
        k = 3;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (s_valid) begin
                found = 1'b1;
                check("t3_first_pc", s_pc, 32'h0000_0100);
                check("t3_first_out", s_out, mem_word(32'h100));
                check("t3_latency", k, 7);
            end
            k++;
        end
        if (!found) timeout("t3_first_valid");

        // Full queue with pops and returns interleaved
        lat_min = 1;
        lat_max = 1;
        do_reset();
        t_rdy = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        exp_seq = 32'h0;
        for (int i = 0; i < 30; i++) begin
            t_rdy = (i % 3) != 0;
            cycle();
            if (s_valid && t_rdy) begin
                check("t4_order", s_pc, exp_seq);
                exp_seq = exp_seq + 32'd4;
            end
        end

        // Address wrap at the top of the address space
        t_rdy = 1'b1;
        t_redir = 1'b1;
        t_rpc = 32'hFFFF_FFFB;
        cycle();
        t_redir = 1'b0;
        wrap_pc[0] = 32'hFFFF_FFF8;
        wrap_pc[1] = 32'hFFFF_FFFC;
        wrap_pc[2] = 32'h0000_0000;
        wrap_pc[3] = 32'h0000_0004;
        seen = 0;
        for (int i = 0; i < 20 && seen < 4; i++) begin
            cycle();
            if (s_valid) begin
                check("t5_wrap_pc", s_pc, wrap_pc[seen]);
                seen++;
            end
        end
        if (seen < 4) timeout("t5_wrap");

        // Reset while entries are queued and reads are outstanding
        lat_min = 2;
        lat_max = 2;
        do_reset();
        t_rdy = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        t_rst = 1'b1;
        cycle();
        t_rst = 1'b0;
        cycle();
        check("t6_req", {31'b0, s_req}, 32'h1);
        check("t6_addr", s_addr, RESET_PC);
        check("t6_valid", {31'b0, s_valid}, 32'h0);
        check("t6_out", s_out, 32'h0);
        check("t6_pc", s_pc, 32'h0);

        // Stray response with nothing outstanding
        do_reset();
        t_mrdy = 1'b0;
        t_spur = 1'b1;
        cycle();
        cycle();
        t_spur = 1'b0;
        cycle();
        check("t7_stray_valid", {31'b0, s_valid}, 32'h0);
        t_mrdy = 1'b1;

        // Randomized traffic against the reference model
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            t_rst   = ($urandom_range(0, 299) == 0);
            t_redir = !t_rst && ($urandom_range(0, 19) == 0);
            t_rpc   = $urandom;
            t_rdy   = ($urandom_range(0, 3) != 0);
            t_mrdy  = ($urandom_range(0, 3) != 0);
            t_spur  = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
